// File: rtl/mips_mem_pkg.sv
// Shared state encoding and constants for the MIPS unified word memory.
package mips_mem_pkg;

  localparam int   WORD_W    = 32;
  localparam logic OP2_READ  = 1'b0;
  localparam logic OP2_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// DEPTH x WORD_W storage: registered fetch read port plus a data read/write port.
// Build option MIPS_MEM_INIT_EN zero-fills the array at start-up.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_fetch_idx,
  output logic [WORD_W-1:0] o_fetch_data,
  input  logic              i_data_en,
  input  logic              i_data_we,
  input  logic [IDX_W-1:0]  i_data_idx,
  input  logic [WORD_W-1:0] i_data_wdata,
  output logic [WORD_W-1:0] o_data_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_fetch_data;
  logic [WORD_W-1:0] r_rdata;

`ifdef MIPS_MEM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] = '0;
    end
  end
`endif

  // Storage write; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (i_data_en && i_data_we) begin
      r_mem[i_data_idx] <= i_data_wdata;
    end
  end

  // Read registers; fetch sees the pre-write word on a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_data <= '0;
      r_rdata      <= '0;
    end else begin
      r_fetch_data <= r_mem[i_fetch_idx];
      if (i_data_en && !i_data_we) begin
        r_rdata <= r_mem[i_data_idx];
      end
    end
  end

  assign o_fetch_data = r_fetch_data;
  assign o_data_rdata = r_rdata;

endmodule

// File: rtl/mips_data_memory.sv
// Unified word memory responder: 1-cycle fetch port and a wait-stated Op2 data port.
// Optional build macro MIPS_MEM_INIT_EN (handled in mips_mem_array) preloads contents.
module mips_data_memory
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadPC,
  output logic [WORD_W-1:0] Instruction,
  input  logic              Op2En,
  input  logic              Op2RW,
  input  logic [ADDR_W-1:0] ReadWriteAddr,
  input  logic [WORD_W-1:0] DataWrite,
  output logic              Op2Ready,
  output logic              Op2Done,
  output logic [WORD_W-1:0] Data
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_M1);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic              w_resp;
  logic [3:0]        r_wait_cnt;
  logic [IDX_W-1:0]  r_req_idx;
  logic              r_req_rw;
  logic [WORD_W-1:0] r_req_wdata;
  logic              r_op2_ready;
  logic              r_op2_done;
  logic              w_unused;

  // Upper address bits are intentionally ignored so addresses wrap modulo DEPTH.
  assign w_unused = ^{ReadPC, ReadWriteAddr};

  // Next-state decode for the data-port handshake.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Op2En) begin
          w_accept     = 1'b1;
          w_next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_resp = (r_state == RESP);

  // State, wait counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_op2_ready <= 1'b1;
      r_op2_done  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_op2_ready <= (w_next_state == IDLE);
      r_op2_done  <= w_resp;
      if (w_accept) begin
        r_wait_cnt <= WAIT_INIT;
      end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // Request capture; later changes on the request inputs cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_idx   <= '0;
      r_req_rw    <= OP2_READ;
      r_req_wdata <= '0;
    end else if (w_accept) begin
      r_req_idx   <= ReadWriteAddr[IDX_W-1:0];
      r_req_rw    <= Op2RW;
      r_req_wdata <= DataWrite;
    end
  end

  mips_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fetch_idx  (ReadPC[IDX_W-1:0]),
    .o_fetch_data (Instruction),
    .i_data_en    (w_resp),
    .i_data_we    (r_req_rw == OP2_WRITE),
    .i_data_idx   (r_req_idx),
    .i_data_wdata (r_req_wdata),
    .o_data_rdata (Data)
  );

  assign Op2Ready = r_op2_ready;
  assign Op2Done  = r_op2_done;

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench for mips_data_memory with three instances: WAIT_CYCLES = 1, 3 and 0.
module tb_mips_data_memory;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic [31:0] pc    [3];
  logic [31:0] instr [3];
  logic        en    [3];
  logic        rw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        done  [3];
  logic [31:0] data  [3];

  int n_checks = 0;
  int n_fail   = 0;

  mips_data_memory #(.DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]), .ReadPC(pc[0]), .Instruction(instr[0]),
    .Op2En(en[0]), .Op2RW(rw[0]), .ReadWriteAddr(addr[0]), .DataWrite(wdata[0]),
    .Op2Ready(ready[0]), .Op2Done(done[0]), .Data(data[0]));

  mips_data_memory #(.DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[1]), .ReadPC(pc[1]), .Instruction(instr[1]),
    .Op2En(en[1]), .Op2RW(rw[1]), .ReadWriteAddr(addr[1]), .DataWrite(wdata[1]),
    .Op2Ready(ready[1]), .Op2Done(done[1]), .Data(data[1]));

  mips_data_memory #(.DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[2]), .ReadPC(pc[2]), .Instruction(instr[2]),
    .Op2En(en[2]), .Op2RW(rw[2]), .ReadWriteAddr(addr[2]), .DataWrite(wdata[2]),
    .Op2Ready(ready[2]), .Op2Done(done[2]), .Data(data[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One data transaction; request inputs are scrambled right after acceptance.
  task automatic xact(input int k, input logic rwv, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_lat, output logic [31:0] rd);
    int cyc;
    bit seen;
    cyc = 0;
    while (!ready[k] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before", 32'(ready[k]), 32'd1);
    en[k] = 1'b1; rw[k] = rwv; addr[k] = a; wdata[k] = wd;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        en[k] = 1'b0; rw[k] = ~rwv; addr[k] = ~a; wdata[k] = ~wd;
        if (exp_lat > 1) check("ready_wait", 32'(ready[k]), 32'd0);
      end
      if (done[k]) seen = 1'b1;
    end
    check("latency", 32'(cyc - 1), 32'(exp_lat));
    rd = data[k];
  endtask

  logic [31:0] rd;
  bit          seen_done;
  int          pulses;
  int          consec;
  logic        prev;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; pc[k] = 32'd0; en[k] = 1'b0; rw[k] = 1'b0;
      addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    check("rst_instr", instr[0], 32'd0);
    check("rst_data",  data[0],  32'd0);
    check("rst_done",  32'(done[0]),  32'd0);
    check("rst_ready", 32'(ready[0]), 32'd1);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);

    // Fetch port after loading two words through the data port.
    xact(0, OP2_WRITE, 32'd0, 32'h00000001, 2, rd);
    xact(0, OP2_WRITE, 32'd1, 32'h00000002, 2, rd);
    pc[0] = 32'd0; @(negedge clk); check("fetch0", instr[0], 32'h00000001);
    pc[0] = 32'd1; @(negedge clk); check("fetch1", instr[0], 32'h00000002);

    xact(0, OP2_WRITE, 32'd2, 32'hDEADBEEF, 2, rd);
    xact(0, OP2_READ,  32'd2, 32'h0, 2, rd);
    check("rd_deadbeef", rd, 32'hDEADBEEF);

    xact(0, OP2_WRITE, 32'd34, 32'h12345678, 2, rd);
    xact(0, OP2_READ,  32'd2,  32'h0, 2, rd);
    check("wrap", rd, 32'h12345678);

    xact(0, OP2_WRITE, 32'd5, 32'hAAAAAAAA, 2, rd);
    check("data_hold", data[0], 32'h12345678);

    // Fetch of index 5 held across a write to index 5.
    pc[0] = 32'd5;
    xact(0, OP2_WRITE, 32'd5, 32'h55555555, 2, rd);
    check("collide_old", instr[0], 32'hAAAAAAAA);
    @(negedge clk);
    check("collide_new", instr[0], 32'h55555555);
    xact(0, OP2_READ, 32'd5, 32'h0, 2, rd);
    check("rd_after_collide", rd, 32'h55555555);

    // WAIT_CYCLES = 3: reset in the second WAIT cycle aborts the write.
    xact(1, OP2_WRITE, 32'd7, 32'h11111111, 4, rd);
    xact(1, OP2_READ,  32'd7, 32'h0, 4, rd);
    check("w3_pre", rd, 32'h11111111);
    en[1] = 1'b1; rw[1] = OP2_WRITE; addr[1] = 32'd7; wdata[1] = 32'hCAFEF00D;
    seen_done = 1'b0;
    @(negedge clk); en[1] = 1'b0; seen_done |= done[1];
    @(negedge clk); seen_done |= done[1]; rst_n[1] = 1'b0;
    #1;
    check("abort_ready", 32'(ready[1]), 32'd1);
    check("abort_data",  data[1], 32'd0);
    @(negedge clk); rst_n[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen_done |= done[1];
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    xact(1, OP2_READ, 32'd7, 32'h0, 4, rd);
    check("abort_mem", rd, 32'h11111111);

    // WAIT_CYCLES = 0 with Op2En held high on reads.
    xact(2, OP2_WRITE, 32'd3, 32'h0BADC0DE, 1, rd);
    en[2] = 1'b1; rw[2] = OP2_READ; addr[2] = 32'd3;
    pulses = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done[2]) pulses++;
      if (done[2] && prev) consec++;
      prev = done[2];
    end
    en[2] = 1'b0;
    check("w0_pulses", 32'(pulses), 32'd5);
    check("w0_consec", 32'(consec), 32'd0);
    check("w0_data",   data[2], 32'h0BADC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
